// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and fetch state encoding for the IF stage
//   XLEN          : data/address width
//   NOP_INSTR     : addi x0,x0,0
//   fetch_state_e : ST_RUN (issuing), ST_DRAIN (discarding squashed responses)
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with async active-low reset and synchronous clear
//   clock, reset_n           : clock, asynchronous active-low reset
//   clear                    : empties the FIFO at the next edge, overrides push/pop
//   s_tvalid/s_tready/s_tdata: write side
//   m_tvalid/m_tready/m_tdata: read side, m_tdata is zero while empty
//   count                    : current occupancy
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   s_tvalid,
  input  logic [WIDTH-1:0]       s_tdata,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [WIDTH-1:0]       m_tdata,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  assign m_tvalid = (cnt != '0);
  assign pop      = m_tvalid && m_tready;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign s_tready = (cnt != (AW+1)'(DEPTH)) || pop;
  assign push     = s_tvalid && s_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
  assign count    = cnt;

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= s_tdata;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end between the PC register and IF/ID
//   Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned PC -> NOP entry, id_misaligned)
//   clock, reset_n                       : clock, asynchronous active-low reset
//   pc_in, pc_enable                     : current PC and its advance strobe
//   flush                                : squash buffered and in-flight fetches
//   imem_req_valid/ready/addr            : in-order fetch requests
//   imem_rsp_valid/data                  : in-order responses, no backpressure
//   id_valid/ready/instr/pc(/misaligned) : buffered instruction to decode
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_enable,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            id_misaligned,
`endif
  output logic [XLEN-1:0] id_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int BW = 2*XLEN + 1;
`else
  localparam int BW = 2*XLEN;
`endif

  fetch_state_e    state;
  logic [CW-1:0]   outstanding;
  logic            started;     // low for the first cycle after reset so outputs stay 0
  logic            wait_flush;  // misaligned NOP issued, hold off until redirected

  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic [CW:0]     in_use;
  logic            credit;
  logic            misaligned;
  logic            misalign_take;
  logic            req_accept;
  logic            rsp_dec;
  logic            rsp_accept;
  logic            tag_valid;
  logic            tag_ready;
  logic            buf_ready;
  logic [XLEN-1:0] tag_pc;
  logic [BW-1:0]   buf_wdata;
  logic [BW-1:0]   buf_rdata;

  assign in_use = {1'b0, outstanding} + {1'b0, buf_count};
  assign credit = started && (state == ST_RUN) && !flush && !wait_flush &&
                  (outstanding < CW'(MAX_OUTSTANDING)) &&
                  (in_use < (CW+1)'(FIFO_DEPTH));

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned    = (pc_in[1:0] != 2'b00);
  // Only with nothing in flight, so the NOP cannot overtake an older response.
  assign misalign_take = credit && misaligned && (outstanding == '0);
  assign buf_wdata     = misalign_take ? {1'b1, pc_in, NOP_INSTR}
                                       : {1'b0, tag_pc, imem_rsp_data};
  assign id_misaligned = buf_rdata[2*XLEN];
`else
  assign misaligned    = 1'b0;
  assign misalign_take = 1'b0;
  assign buf_wdata     = {tag_pc, imem_rsp_data};
`endif

  assign imem_req_valid = credit && !misaligned;
  assign imem_req_addr  = imem_req_valid ? {pc_in[XLEN-1:2], 2'b00} : '0;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign pc_enable      = req_accept || misalign_take;

  // Every response retires one in-flight request; only RUN-state ones are kept.
  assign rsp_dec    = imem_rsp_valid && (outstanding != '0);
  assign rsp_accept = imem_rsp_valid && (state == ST_RUN) && !flush;

  assign id_instr = buf_rdata[XLEN-1:0];
  assign id_pc    = buf_rdata[2*XLEN-1:XLEN];

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (flush),
    .s_tvalid (req_accept),
    .s_tdata  (pc_in),
    .s_tready (tag_ready),
    .m_tvalid (tag_valid),
    .m_tdata  (tag_pc),
    .m_tready (imem_rsp_valid && (state == ST_RUN)),
    .count    (tag_count)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (flush),
    .s_tvalid (rsp_accept || misalign_take),
    .s_tdata  (buf_wdata),
    .s_tready (buf_ready),
    .m_tvalid (id_valid),
    .m_tdata  (buf_rdata),
    .m_tready (id_ready),
    .count    (buf_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      outstanding <= '0;
      started     <= 1'b0;
      wait_flush  <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_accept) - CW'(rsp_dec);
      if (flush)              wait_flush <= 1'b0;
      else if (misalign_take) wait_flush <= 1'b1;
      case (state)
        ST_RUN: begin
          if (flush && ((outstanding - CW'(rsp_dec)) != '0)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rsp_dec && (outstanding == CW'(1))) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  a_rsp_has_tag: assert property (@(posedge clock) disable iff (!reset_n)
    (imem_rsp_valid && (state == ST_RUN)) |-> tag_valid);
  a_tag_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    req_accept |-> (tag_ready && (tag_count < CW'(FIFO_DEPTH))));
  a_buf_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (rsp_accept || misalign_take) |-> buf_ready);
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misaligned;
`endif

  logic        pc_load;
  logic [31:0] pc_load_val;
  int          pc_en_cnt = 0;
  int          vec = 0;
  int          errs = 0;

  always #5 clock = ~clock;

  // External PC register: redirect load wins over the fetch-unit advance.
  always @(posedge clock) begin
    if (pc_load)        pc_in <= pc_load_val;
    else if (pc_enable) pc_in <= pc_in + 32'd4;
    if (pc_enable)      pc_en_cnt <= pc_en_cnt + 1;
  end

  if_fetch_unit #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pc_in          (pc_in),
    .pc_enable      (pc_enable),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .id_misaligned  (id_misaligned),
`endif
    .id_pc          (id_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    imem_req_ready = 1'b0;
    pc_load = 1'b1;
    pc_load_val = v;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; id_ready = 1'b0; pc_load = 1'b1; pc_load_val = 32'h0;
    #2 reset_n = 1'b0;
    tick(); tick();
    vec++; if (pc_enable !== 1'b0) begin errs++; $display("FAIL rst_pc_enable got=%b exp=0", pc_enable); end
    vec++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    vec++; if (imem_req_addr !== 32'h0) begin errs++; $display("FAIL rst_req_addr got=%h exp=0", imem_req_addr); end
    vec++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
    vec++; if (id_instr !== 32'h0) begin errs++; $display("FAIL rst_id_instr got=%h exp=0", id_instr); end
    vec++; if (id_pc !== 32'h0) begin errs++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
    reset_n = 1'b1;
    pc_load = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    id_ready = 1'b0;
    load_pc(32'h100);
    imem_req_ready = 1'b1;
    #1;
    vec++; if (pc_enable !== 1'b1 || imem_req_addr !== 32'h100) begin errs++; $display("FAIL mid_first_req got=%b/%h exp=1/00000100", pc_enable, imem_req_addr); end
    tick();
    vec++; if (imem_req_addr !== 32'h104) begin errs++; $display("FAIL mid_second_req got=%h exp=00000104", imem_req_addr); end
    tick();
    vec++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL mid_credit_limit got=%b exp=0", imem_req_valid); end
    reset_n = 1'b0;
    #1;
    vec++; if ({pc_enable, imem_req_valid, id_valid} !== 3'b000 || imem_req_addr !== 32'h0 || id_instr !== 32'h0 || id_pc !== 32'h0)
      begin errs++; $display("FAIL mid_async_reset got=%b%b%b/%h/%h/%h exp=000/0/0/0", pc_enable, imem_req_valid, id_valid, imem_req_addr, id_instr, id_pc); end
    tick();
    reset_n = 1'b1;
    imem_req_ready = 1'b0;
    tick(); tick(); tick();
    vec++; if (id_valid !== 1'b0) begin errs++; $display("FAIL mid_no_stale got=%b exp=0", id_valid); end
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h108) begin errs++; $display("FAIL mid_credit_restored got=%b/%h exp=1/00000108", imem_req_valid, imem_req_addr); end
  endtask

  // Latency-1 memory; accepts up to n_req requests and pops whatever decode sees.
  task automatic run_stream(input logic [31:0] base, input int n_req, input int n_pop,
                            input int cycles, output int acc, output int pops);
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] exp_addr;
    logic [31:0] exp_id;
    pend = 1'b0; paddr = '0; exp_addr = base; exp_id = base; acc = 0; pops = 0;
    for (int i = 0; i < cycles && pops < n_pop; i++) begin
      imem_rsp_valid = pend;
      imem_rsp_data  = instr_of(paddr);
      pend = 1'b0;
      imem_req_ready = (acc < n_req);
      #1;
      if (pc_enable) begin
        vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin errs++; $display("FAIL stream_req_addr got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, exp_addr); end
        pend = 1'b1; paddr = exp_addr; exp_addr += 4; acc++;
      end
      if (id_valid && id_ready) begin
        vec++; if (id_pc !== exp_id || id_instr !== instr_of(exp_id)) begin errs++; $display("FAIL stream_id got=%h/%h exp=%h/%h", id_pc, id_instr, exp_id, instr_of(exp_id)); end
        exp_id += 4; pops++;
      end
      tick();
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int acc, pops, en0;
    load_pc(32'h0);
    id_ready = 1'b1;
    en0 = pc_en_cnt;
    run_stream(32'h0, 3, 3, 20, acc, pops);
    vec++; if (pops !== 3) begin errs++; $display("FAIL stream_pops got=%0d exp=3", pops); end
    vec++; if (pc_en_cnt - en0 !== 3) begin errs++; $display("FAIL stream_pc_enables got=%0d exp=3", pc_en_cnt - en0); end
    vec++; if (pc_in !== 32'hC) begin errs++; $display("FAIL stream_final_pc got=%h exp=0000000c", pc_in); end
  endtask

  task automatic test_backpressure();
    int acc, pops;
    id_ready = 1'b0;
    load_pc(32'h200);
    run_stream(32'h200, 8, 1, 8, acc, pops);
    vec++; if (acc !== 2) begin errs++; $display("FAIL bp_accepts got=%0d exp=2", acc); end
    imem_req_ready = 1'b1;
    #1;
    vec++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin errs++; $display("FAIL bp_stalled got=%b/%b exp=0/0", imem_req_valid, pc_enable); end
    vec++; if (id_pc !== 32'h200 || id_instr !== instr_of(32'h200)) begin errs++; $display("FAIL bp_head got=%h/%h exp=00000200/%h", id_pc, id_instr, instr_of(32'h200)); end
    imem_req_ready = 1'b0;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h208 || id_pc !== 32'h204) begin errs++; $display("FAIL bp_after_pop got=%b/%h/%h exp=1/00000208/00000204", imem_req_valid, imem_req_addr, id_pc); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_flush_drain();
    id_ready = 1'b1;
    load_pc(32'h300);
    imem_req_ready = 1'b1;
    tick(); tick();
    vec++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL fd_two_outstanding got=%b exp=0", imem_req_valid); end
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h400;
    #1;
    vec++; if (pc_enable !== 1'b0) begin errs++; $display("FAIL fd_no_pc_enable_on_flush got=%b exp=0", pc_enable); end
    tick();
    flush = 1'b0; pc_load = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    vec++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errs++; $display("FAIL fd_drain_hold got=%b/%b exp=0/0", imem_req_valid, id_valid); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    vec++; if (id_valid !== 1'b0) begin errs++; $display("FAIL fd_discarded got=%b exp=0", id_valid); end
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin errs++; $display("FAIL fd_resume got=%b/%h exp=1/00000400", imem_req_valid, imem_req_addr); end
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    vec++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_instr !== 32'h1234_5678) begin errs++; $display("FAIL fd_new_entry got=%b/%h/%h exp=1/00000400/12345678", id_valid, id_pc, id_instr); end
    tick();
  endtask

  task automatic test_pushpop_flush_rsp();
    id_ready = 1'b0;
    load_pc(32'h500);
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'h500);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_data = instr_of(32'h504);
    id_ready = 1'b1;
    #1;
    vec++; if (id_pc !== 32'h500) begin errs++; $display("FAIL pp_head_before got=%h exp=00000500", id_pc); end
    tick();
    imem_rsp_valid = 1'b0; id_ready = 1'b0;
    #1;
    vec++; if (id_valid !== 1'b1 || id_pc !== 32'h504 || id_instr !== instr_of(32'h504)) begin errs++; $display("FAIL pp_count_stable got=%b/%h/%h exp=1/00000504/%h", id_valid, id_pc, id_instr, instr_of(32'h504)); end
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h508) begin errs++; $display("FAIL pp_one_credit got=%b/%h exp=1/00000508", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h600;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; pc_load = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    vec++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errs++; $display("FAIL pp_flush_rsp_dropped got=%b/%h exp=0/0", id_valid, id_instr); end
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h600) begin errs++; $display("FAIL pp_stays_run got=%b/%h exp=1/00000600", imem_req_valid, imem_req_addr); end
    tick(); tick();
    vec++; if (id_valid !== 1'b0) begin errs++; $display("FAIL pp_nothing_late got=%b exp=0", id_valid); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misaligned();
    id_ready = 1'b0;
    load_pc(32'h0000_1002);
    imem_req_ready = 1'b1;
    #1;
    vec++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b1) begin errs++; $display("FAIL mis_no_req got=%b/%b exp=0/1", imem_req_valid, pc_enable); end
    tick();
    vec++; if (id_valid !== 1'b1 || id_instr !== 32'h0000_0013 || id_pc !== 32'h0000_1002 || id_misaligned !== 1'b1)
      begin errs++; $display("FAIL mis_nop_entry got=%b/%h/%h/%b exp=1/00000013/00001002/1", id_valid, id_instr, id_pc, id_misaligned); end
    vec++; if (imem_req_valid !== 1'b0 || pc_enable !== 1'b0) begin errs++; $display("FAIL mis_wait_flush got=%b/%b exp=0/0", imem_req_valid, pc_enable); end
    imem_req_ready = 1'b0;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'h2000;
    tick();
    flush = 1'b0; pc_load = 1'b0;
    #1;
    vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000 || id_valid !== 1'b0) begin errs++; $display("FAIL mis_resume got=%b/%h/%b exp=1/00002000/0", imem_req_valid, imem_req_addr, id_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_streaming();
    test_backpressure();
    test_flush_drain();
    test_pushpop_flush_rsp();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
